// File: rtl/xsleena_sdr_arbiter_pkg.sv
// Shared types and constants for the SDRAM read-port arbiter.
// Channel indices, FSM state encoding, default bus widths.
package xsleena_sdr_pkg;

    localparam int CH_MCPU = 0;
    localparam int CH_SCPU = 1;
    localparam int CH_OBJ  = 2;
    localparam int CH_BG1  = 3;
    localparam int CH_BG2  = 4;

    localparam int SDR_NCH = 5;
    localparam int SDR_AW  = 25;
    localparam int SDR_DW  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_st_t;

    // Round-robin successor: wraps from the last channel back
    // to the first video channel.
    function automatic logic [2:0] rr_next(
        input logic [2:0] g,
        input int         nch,
        input int         ncpu
    );
        return (g == 3'(nch - 1)) ? 3'(ncpu) : g + 3'd1;
    endfunction

endpackage

// File: rtl/xsleena_sdr_arbiter_if.sv
// Bundle of requester-side and controller-side arbiter signals.
// master: the arbiter; slave: requesters plus SDRAM controller.
interface xsleena_sdr_arbiter_if
    import xsleena_sdr_pkg::*;
#(
    parameter int NCH = SDR_NCH,
    parameter int AW  = SDR_AW,
    parameter int DW  = SDR_DW
);
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_rdy;
    logic [NCH*DW-1:0] ch_dout;
    logic [AW-1:0]     sdr_addr;
    logic              sdr_req;
    logic              sdr_rdy;
    logic [DW-1:0]     sdr_dout;
    logic [2:0]        grant;
    logic              busy;

    modport master (
        input  ch_addr, ch_req, sdr_rdy, sdr_dout,
        output ch_rdy, ch_dout, sdr_addr, sdr_req,
        output grant, busy
    );

    modport slave (
        output ch_addr, ch_req, sdr_rdy, sdr_dout,
        input  ch_rdy, ch_dout, sdr_addr, sdr_req,
        input  grant, busy
    );
endinterface

// File: rtl/xsleena_sdr_arbiter_rr_pick.sv
// Combinational round-robin selector over channels LO..N-1.
// mask_i: eligible channels; ptr_i: first index searched; valid_o/idx_o: winner.
module xsleena_rr_pick #(
    parameter int N  = 5,
    parameter int LO = 2
) (
    input  logic [N-1:LO] mask_i,
    input  logic [2:0]    ptr_i,
    output logic          valid_o,
    output logic [2:0]    idx_o
);
    localparam int NV = N - LO;

    logic [3:0] j;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'(LO);
        j       = '0;
        for (int k = 0; k < NV; k++) begin
            j = {1'b0, ptr_i} + 4'(k);
            if (j >= 4'(N)) begin
                j = j - 4'(NV);
            end
            if (!valid_o && mask_i[j[2:0]]) begin
                valid_o = 1'b1;
                idx_o   = j[2:0];
            end
        end
    end
endmodule

// File: rtl/xsleena_sdr_arbiter.sv
// Shares one SDRAM read port among CPU and video ROM requesters.
// Ports: CLK, RSTn (sync, active low), bus (master modport of the arbiter interface).
module xsleena_sdr_arbiter
    import xsleena_sdr_pkg::*;
#(
    parameter int NCH      = SDR_NCH,
    parameter int NCPU     = 2,
    parameter int AW       = SDR_AW,
    parameter int DW       = SDR_DW,
    parameter int MAX_WAIT = 64
) (
    input logic                  CLK,
    input logic                  RSTn,
    xsleena_sdr_arbiter_if.master bus
);
    localparam int         CW    = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

    arb_st_t           st_q, st_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              req_q, req_d;
    logic [NCH-1:0]    rdy_q, rdy_d;
    logic [NCH-1:0]    mask_q;
    logic [NCH*DW-1:0] dout_q, dout_d;
    logic [CW-1:0]     cnt_q [NCPU:NCH-1];
    logic [CW-1:0]     cnt_d [NCPU:NCH-1];

    logic [NCH-1:0] elig;
    logic           frc_v, cpu_v, rr_v, pick_v;
    logic [2:0]     frc_idx, cpu_idx, rr_idx, pick_idx;

    // A channel that just saw ch_rdy is masked for one cycle so
    // it can drop its request without causing a second read.
    assign elig = bus.ch_req & ~mask_q;

    xsleena_rr_pick #(
        .N  (NCH),
        .LO (NCPU)
    ) u_rr (
        .mask_i  (elig[NCH-1:NCPU]),
        .ptr_i   (ptr_q),
        .valid_o (rr_v),
        .idx_o   (rr_idx)
    );

    // Starved video channels and CPU channels: lowest index wins,
    // so scan downward and let the last hit stick.
    always_comb begin
        frc_v   = 1'b0;
        frc_idx = '0;
        for (int i = NCH - 1; i >= NCPU; i--) begin
            if (elig[i] && cnt_q[i] == CMAX) begin
                frc_v   = 1'b1;
                frc_idx = 3'(i);
            end
        end
        cpu_v   = 1'b0;
        cpu_idx = '0;
        for (int i = NCPU - 1; i >= 0; i--) begin
            if (elig[i]) begin
                cpu_v   = 1'b1;
                cpu_idx = 3'(i);
            end
        end
    end

    always_comb begin
        pick_v   = frc_v | cpu_v | rr_v;
        pick_idx = rr_idx;
        priority case (1'b1)
            frc_v:   pick_idx = frc_idx;
            cpu_v:   pick_idx = cpu_idx;
            default: pick_idx = rr_idx;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        req_d   = req_q;
        rdy_d   = '0;
        dout_d  = dout_q;
        unique case (st_q)
            IDLE: begin
                if (pick_v) begin
                    grant_d = pick_idx;
                    addr_d  = bus.ch_addr[int'(pick_idx)*AW +: AW];
                    st_d    = ISSUE;
                    if (pick_idx >= 3'(NCPU)) begin
                        ptr_d = rr_next(pick_idx, NCH, NCPU);
                    end
                end
            end
            ISSUE: begin
                req_d = 1'b1;
                st_d  = WAIT;
            end
            WAIT: begin
                if (bus.sdr_rdy) begin
                    dout_d[int'(grant_q)*DW +: DW] = bus.sdr_dout;
                    rdy_d[grant_q] = 1'b1;
                    req_d          = 1'b0;
                    st_d           = DONE;
                end
            end
            DONE: begin
                st_d = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // A counter runs only while its channel requests and does not
    // own the port; it saturates at MAX_WAIT.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = NCPU; i < NCH; i++) begin
            if (!bus.ch_req[i]) begin
                cnt_d[i] = '0;
            end else if ((st_q == IDLE && pick_v &&
                          pick_idx == 3'(i)) ||
                         (st_q != IDLE && grant_q == 3'(i))) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CMAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            st_q    <= IDLE;
            grant_q <= '0;
            ptr_q   <= 3'(NCPU);
            addr_q  <= '0;
            req_q   <= 1'b0;
            rdy_q   <= '0;
            mask_q  <= '0;
            dout_q  <= '0;
            for (int i = NCPU; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            st_q    <= st_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            rdy_q   <= rdy_d;
            mask_q  <= rdy_q;
            dout_q  <= dout_d;
            for (int i = NCPU; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.ch_rdy   = rdy_q;
    assign bus.ch_dout  = dout_q;
    assign bus.sdr_addr = addr_q;
    assign bus.sdr_req  = req_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (st_q == ISSUE) || (st_q == WAIT);
endmodule

// File: tb/tb_xsleena_sdr_arbiter.sv
// Directed bench for the SDRAM arbiter: one DUT at default
// MAX_WAIT, a second at MAX_WAIT=8 for the starvation guard.
module tb_xsleena_sdr_arbiter;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    xsleena_sdr_arbiter_if sif ();
    xsleena_sdr_arbiter_if sif8 ();

    xsleena_sdr_arbiter u_dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (sif)
    );

    xsleena_sdr_arbiter #(.MAX_WAIT(8)) u_dut8 (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (sif8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic serve(
        input  bit          w8,
        input  int          lat,
        input  logic [15:0] data,
        input  bit          drop,
        output int          g,
        output logic [24:0] a,
        output logic [4:0]  rdy,
        output bit          ok
    );
        ok  = 1'b0;
        g   = -1;
        a   = '0;
        rdy = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = w8 ? (sif8.sdr_req === 1'b1) : (sif.sdr_req === 1'b1);
        end
        if (!ok) return;
        g = w8 ? int'(sif8.grant) : int'(sif.grant);
        a = w8 ? sif8.sdr_addr : sif.sdr_addr;
        repeat (lat) @(negedge clk);
        if (w8) begin
            sif8.sdr_rdy  = 1'b1;
            sif8.sdr_dout = data;
        end else begin
            sif.sdr_rdy  = 1'b1;
            sif.sdr_dout = data;
        end
        @(negedge clk);
        if (w8) begin
            sif8.sdr_rdy = 1'b0;
            rdy = sif8.ch_rdy;
            if (drop) sif8.ch_req[g] = 1'b0;
        end else begin
            sif.sdr_rdy = 1'b0;
            rdy = sif.ch_rdy;
            if (drop) sif.ch_req[g] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (sif.sdr_req !== 1'b0 || sif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_busy: got %b%b want 00",
                     sif.sdr_req, sif.busy);
        end
        n_tests++;
        if (sif.ch_rdy !== 5'b0 || sif.ch_dout !== 80'b0) begin
            n_fail++;
            $display("FAIL rst_ch: rdy %b dout %h want 0",
                     sif.ch_rdy, sif.ch_dout);
        end
        n_tests++;
        if (sif.grant !== 3'd0 || sif.sdr_addr !== 25'd0) begin
            n_fail++;
            $display("FAIL rst_grant_addr: got %0d %h want 0 0",
                     sif.grant, sif.sdr_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [24:0] a0;
        a0 = 25'h1ABCDE;
        sif.ch_addr[24:0] = a0;
        sif.ch_req = 5'b00001;
        @(negedge clk);
        n_tests++;
        if (sif.sdr_req !== 1'b0 || sif.busy !== 1'b1 ||
            sif.grant !== 3'd0 || sif.sdr_addr !== a0) begin
            n_fail++;
            $display("FAIL single_issue: req %b busy %b g %0d a %h want 0 1 0 %h",
                     sif.sdr_req, sif.busy, sif.grant, sif.sdr_addr, a0);
        end
        sif.ch_addr[24:0] = 25'h0055AA;
        @(negedge clk);
        n_tests++;
        if (sif.sdr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: sdr_req %b want 1", sif.sdr_req);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (sif.sdr_addr !== a0 || sif.sdr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: addr %h req %b want %h 1",
                     sif.sdr_addr, sif.sdr_req, a0);
        end
        sif.sdr_rdy  = 1'b1;
        sif.sdr_dout = 16'hA55A;
        @(negedge clk);
        sif.sdr_rdy = 1'b0;
        n_tests++;
        if (sif.ch_rdy !== 5'b00001 || sif.sdr_req !== 1'b0 ||
            sif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rdy: rdy %b req %b busy %b want 00001 0 0",
                     sif.ch_rdy, sif.sdr_req, sif.busy);
        end
        n_tests++;
        if (sif.ch_dout[15:0] !== 16'hA55A ||
            sif.ch_dout[79:16] !== 64'b0) begin
            n_fail++;
            $display("FAIL single_dout: got %h want 0..0A55A", sif.ch_dout);
        end
        sif.ch_req = 5'b0;
        @(negedge clk);
        n_tests++;
        if (sif.ch_rdy !== 5'b0) begin
            n_fail++;
            $display("FAIL single_pulse: rdy %b want 0", sif.ch_rdy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int          g;
        logic [24:0] a;
        logic [4:0]  rdy;
        bit          ok;
        int          expa [3];
        int          expb [4];
        logic [15:0] dat  [3];
        logic [24:0] adr  [5];
        expa = '{0, 2, 3};
        expb = '{0, 2, 0, 3};
        dat  = '{16'h1111, 16'h2222, 16'h3333};
        adr  = '{25'h0000100, 25'h0000200, 25'h0000300,
                 25'h0000400, 25'h0000500};
        for (int i = 0; i < 5; i++) sif.ch_addr[i*25 +: 25] = adr[i];
        sif.ch_req = 5'b01101;
        for (int t = 0; t < 3; t++) begin
            serve(1'b0, 1, dat[t], 1'b1, g, a, rdy, ok);
            if (t == 0) sif.ch_addr[3*25 +: 25] = 25'h1F0F0F0;
            n_tests++;
            if (!ok || g != expa[t] || rdy !== 5'(1 << expa[t])) begin
                n_fail++;
                $display("FAIL rr_a_grant%0d: ok %0b g %0d rdy %b want g %0d",
                         t, ok, g, rdy, expa[t]);
            end
            n_tests++;
            if (t == 2 ? (a !== 25'h1F0F0F0) : (a !== adr[expa[t]])) begin
                n_fail++;
                $display("FAIL rr_a_addr%0d: got %h", t, a);
            end
        end
        n_tests++;
        if (sif.ch_dout[0 +: 16] !== 16'h1111 ||
            sif.ch_dout[32 +: 16] !== 16'h2222 ||
            sif.ch_dout[48 +: 16] !== 16'h3333 ||
            sif.ch_dout[16 +: 16] !== 16'h0000 ||
            sif.ch_dout[64 +: 16] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rr_a_dout: got %h want 0000_3333_2222_0000_1111",
                     sif.ch_dout);
        end
        repeat (2) @(negedge clk);
        sif.ch_req = 5'b01101;
        for (int t = 0; t < 4; t++) begin
            serve(1'b0, 0, 16'h4000 + 16'(t), 1'b0, g, a, rdy, ok);
            n_tests++;
            if (!ok || g != expb[t]) begin
                n_fail++;
                $display("FAIL rr_b_grant%0d: ok %0b g %0d want %0d",
                         t, ok, g, expb[t]);
            end
        end
        sif.ch_req = 5'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_starvation();
        int          g;
        logic [24:0] a;
        logic [4:0]  rdy;
        bit          ok;
        int          exp_g [4];
        exp_g = '{0, 1, 4, 0};
        sif8.ch_addr = '0;
        sif8.ch_addr[4*25 +: 25] = 25'h0ABCDE;
        sif8.ch_req = 5'b10011;
        for (int t = 0; t < 4; t++) begin
            serve(1'b1, 0, 16'h8000 + 16'(t), 1'b0, g, a, rdy, ok);
            n_tests++;
            if (!ok || g != exp_g[t] || rdy !== 5'(1 << exp_g[t])) begin
                n_fail++;
                $display("FAIL starve_grant%0d: ok %0b g %0d rdy %b want %0d",
                         t, ok, g, rdy, exp_g[t]);
            end
        end
        n_tests++;
        if (sif8.ch_dout[64 +: 16] !== 16'h8002) begin
            n_fail++;
            $display("FAIL starve_dout: got %h want 8002",
                     sif8.ch_dout[64 +: 16]);
        end
        sif8.ch_req = 5'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hold_after_rdy();
        int          g;
        logic [24:0] a;
        logic [4:0]  rdy;
        bit          ok;
        bit          seen;
        sif.ch_req = 5'b00100;
        serve(1'b0, 2, 16'h5A5A, 1'b0, g, a, rdy, ok);
        n_tests++;
        if (!ok || g != 2 || rdy !== 5'b00100) begin
            n_fail++;
            $display("FAIL hold_grant: ok %0b g %0d rdy %b want 2 00100",
                     ok, g, rdy);
        end
        @(negedge clk);
        @(negedge clk);
        seen = (sif.busy !== 1'b0);
        sif.ch_req = 5'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sif.busy !== 1'b0 || sif.sdr_req !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL hold_no_reissue: second transaction seen, want none");
        end
    endtask

    task automatic test_stray_idle();
        logic [2:0]  g0;
        logic [79:0] d0;
        g0 = sif.grant;
        d0 = sif.ch_dout;
        sif.sdr_rdy  = 1'b1;
        sif.sdr_dout = 16'hDEAD;
        @(negedge clk);
        sif.sdr_rdy = 1'b0;
        n_tests++;
        if (sif.ch_rdy !== 5'b0 || sif.busy !== 1'b0 ||
            sif.sdr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: rdy %b busy %b req %b want 0 0 0",
                     sif.ch_rdy, sif.busy, sif.sdr_req);
        end
        @(negedge clk);
        n_tests++;
        if (sif.grant !== g0 || sif.ch_dout !== d0 || sif.ch_rdy !== 5'b0) begin
            n_fail++;
            $display("FAIL stray_state: g %0d dout %h want %0d %h",
                     sif.grant, sif.ch_dout, g0, d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 1'b0;
        sif.ch_addr[3*25 +: 25] = 25'h0123456;
        sif.ch_req = 5'b01000;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (sif.sdr_req === 1'b1);
        end
        n_tests++;
        if (!ok || sif.grant !== 3'd3) begin
            n_fail++;
            $display("FAIL rmid_start: ok %0b g %0d want 1 3", ok, sif.grant);
        end
        rstn = 1'b0;
        sif.ch_req = 5'b0;
        @(negedge clk);
        n_tests++;
        if (sif.sdr_req !== 1'b0 || sif.busy !== 1'b0 ||
            sif.ch_rdy !== 5'b0 || sif.ch_dout !== 80'b0 ||
            sif.grant !== 3'd0 || sif.sdr_addr !== 25'd0) begin
            n_fail++;
            $display("FAIL rmid_reset: req %b busy %b rdy %b g %0d dout %h",
                     sif.sdr_req, sif.busy, sif.ch_rdy, sif.grant, sif.ch_dout);
        end
        rstn = 1'b1;
        @(negedge clk);
        sif.sdr_rdy  = 1'b1;
        sif.sdr_dout = 16'hBEEF;
        @(negedge clk);
        sif.sdr_rdy = 1'b0;
        n_tests++;
        if (sif.ch_rdy !== 5'b0 || sif.ch_dout !== 80'b0) begin
            n_fail++;
            $display("FAIL rmid_stray: rdy %b dout %h want 0 0",
                     sif.ch_rdy, sif.ch_dout);
        end
        @(negedge clk);
        n_tests++;
        if (sif.ch_rdy !== 5'b0 || sif.busy !== 1'b0 ||
            sif.sdr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_idle: rdy %b busy %b req %b want 0 0 0",
                     sif.ch_rdy, sif.busy, sif.sdr_req);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        sif.ch_addr   = '0;
        sif.ch_req    = '0;
        sif.sdr_rdy   = 1'b0;
        sif.sdr_dout  = '0;
        sif8.ch_addr  = '0;
        sif8.ch_req   = '0;
        sif8.sdr_rdy  = 1'b0;
        sif8.sdr_dout = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_hold_after_rdy();
        test_stray_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
